// File: rtl/udp_port_mux.sv
// UDP port demultiplexer / round-robin TX multiplexer for NUM_CH channels.
// Define UDP_PORT_MUX_STATS_EN to enable the saturating drop counter.
module udp_port_mux #(
  parameter int          NUM_CH    = 4,
  parameter logic [15:0] BASE_PORT = 16'd1234,
  parameter logic [7:0]  TTL       = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           local_ip,
  input  logic                  rx_udp_hdr_valid,
  output logic                  rx_udp_hdr_ready,
  input  logic [31:0]           rx_udp_ip_source_ip,
  input  logic [15:0]           rx_udp_source_port,
  input  logic [15:0]           rx_udp_dest_port,
  input  logic [7:0]            rx_udp_payload_axis_tdata,
  input  logic                  rx_udp_payload_axis_tvalid,
  output logic                  rx_udp_payload_axis_tready,
  input  logic                  rx_udp_payload_axis_tlast,
  input  logic                  rx_udp_payload_axis_tuser,
  output logic                  tx_udp_hdr_valid,
  input  logic                  tx_udp_hdr_ready,
  output logic [31:0]           tx_udp_ip_source_ip,
  output logic [31:0]           tx_udp_ip_dest_ip,
  output logic [15:0]           tx_udp_source_port,
  output logic [15:0]           tx_udp_dest_port,
  output logic [15:0]           tx_udp_length,
  output logic [7:0]            tx_udp_ip_ttl,
  output logic [5:0]            tx_udp_ip_dscp,
  output logic [1:0]            tx_udp_ip_ecn,
  output logic [15:0]           tx_udp_checksum,
  output logic [7:0]            tx_udp_payload_axis_tdata,
  output logic                  tx_udp_payload_axis_tvalid,
  input  logic                  tx_udp_payload_axis_tready,
  output logic                  tx_udp_payload_axis_tlast,
  output logic                  tx_udp_payload_axis_tuser,
  output logic [NUM_CH*8-1:0]   m_tdata,
  output logic [NUM_CH-1:0]     m_tvalid,
  output logic [NUM_CH-1:0]     m_tlast,
  output logic [NUM_CH-1:0]     m_tuser,
  input  logic [NUM_CH-1:0]     m_tready,
  input  logic [NUM_CH*8-1:0]   s_tdata,
  input  logic [NUM_CH-1:0]     s_tvalid,
  input  logic [NUM_CH-1:0]     s_tlast,
  input  logic [NUM_CH-1:0]     s_tuser,
  output logic [NUM_CH-1:0]     s_tready,
  input  logic [NUM_CH*16-1:0]  s_len,
  output logic [NUM_CH-1:0]     ch_bound,
  output logic                  status_drop_frame,
  output logic [15:0]           status_drop_count
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_PASS, R_DROP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY} tx_state_t;

  rx_state_t r_rx_st, w_rx_nxt;
  tx_state_t r_tx_st, w_tx_nxt;

  logic [IW-1:0]     r_sel;
  logic [31:0]       r_hdr_ip;
  logic [15:0]       r_hdr_port;
  logic [31:0]       r_ctx_ip   [NUM_CH];
  logic [15:0]       r_ctx_port [NUM_CH];
  logic [NUM_CH-1:0] r_bound;
  logic              r_drop;

  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_g;
  logic [15:0]       r_len;
  logic [31:0]       r_dip;
  logic [15:0]       r_dport;

  logic [15:0]       w_idx;
  logic              w_hit;
  logic              w_hdr_hs;
  logic              w_rx_hs;
  logic              w_pass_end;
  logic [NUM_CH-1:0] w_cand;
  logic              w_any;
  logic [IW-1:0]     w_pick;
  logic              w_tx_end;

  assign w_idx      = rx_udp_dest_port - BASE_PORT;
  assign w_hit      = w_idx < 16'(NUM_CH);
  assign w_hdr_hs   = rx_udp_hdr_valid && rx_udp_hdr_ready;
  assign w_rx_hs    = rx_udp_payload_axis_tvalid
                   && rx_udp_payload_axis_tready;
  assign w_pass_end = (r_rx_st == R_PASS) && w_rx_hs
                   && rx_udp_payload_axis_tlast;

  assign m_tdata = {NUM_CH{rx_udp_payload_axis_tdata}};
  assign m_tlast = {NUM_CH{rx_udp_payload_axis_tlast}};
  assign m_tuser = {NUM_CH{rx_udp_payload_axis_tuser}};

  always_comb begin
    w_rx_nxt                   = r_rx_st;
    rx_udp_hdr_ready           = 1'b0;
    rx_udp_payload_axis_tready = 1'b0;
    m_tvalid                   = '0;
    unique case (r_rx_st)
      R_IDLE: begin
        rx_udp_hdr_ready = !rst;
        if (w_hdr_hs) w_rx_nxt = w_hit ? R_PASS : R_DROP;
      end
      R_PASS: begin
        rx_udp_payload_axis_tready = m_tready[r_sel];
        m_tvalid[r_sel] = rx_udp_payload_axis_tvalid;
        if (w_pass_end) w_rx_nxt = R_IDLE;
      end
      R_DROP: begin
        rx_udp_payload_axis_tready = 1'b1;
        if (w_rx_hs && rx_udp_payload_axis_tlast) w_rx_nxt = R_IDLE;
      end
      default: w_rx_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st    <= R_IDLE;
      r_sel      <= '0;
      r_hdr_ip   <= '0;
      r_hdr_port <= '0;
      r_bound    <= '0;
      r_drop     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_ctx_ip[i]   <= '0;
        r_ctx_port[i] <= '0;
      end
    end else begin
      r_rx_st <= w_rx_nxt;
      r_drop  <= w_hdr_hs && !w_hit;
      if (w_hdr_hs) begin
        r_sel      <= w_idx[IW-1:0];
        r_hdr_ip   <= rx_udp_ip_source_ip;
        r_hdr_port <= rx_udp_source_port;
      end
      // Only a clean frame may (re)bind the reply context.
      if (w_pass_end && !rx_udp_payload_axis_tuser) begin
        r_ctx_ip[r_sel]   <= r_hdr_ip;
        r_ctx_port[r_sel] <= r_hdr_port;
        r_bound[r_sel]    <= 1'b1;
      end
    end
  end

  assign ch_bound          = r_bound;
  assign status_drop_frame = r_drop;

`ifdef UDP_PORT_MUX_STATS_EN
  logic [15:0] r_drop_cnt;
  logic        w_cnt_evt;
  assign w_cnt_evt = r_drop || (w_pass_end && rx_udp_payload_axis_tuser);
  always_ff @(posedge clk) begin
    if (rst) r_drop_cnt <= '0;
    else if (w_cnt_evt && r_drop_cnt != 16'hFFFF)
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign status_drop_count = r_drop_cnt;
`else
  assign status_drop_count = 16'd0;
`endif

  assign w_cand = s_tvalid & r_bound;

  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_cand[(int'(r_ptr) + k) % NUM_CH]) begin
        w_any  = 1'b1;
        w_pick = IW'((int'(r_ptr) + k) % NUM_CH);
      end
    end
  end

  assign w_tx_end = (r_tx_st == T_PAY) && s_tvalid[r_g]
                 && tx_udp_payload_axis_tready && s_tlast[r_g];

  always_comb begin
    w_tx_nxt                   = r_tx_st;
    tx_udp_hdr_valid           = 1'b0;
    tx_udp_payload_axis_tdata  = '0;
    tx_udp_payload_axis_tvalid = 1'b0;
    tx_udp_payload_axis_tlast  = 1'b0;
    tx_udp_payload_axis_tuser  = 1'b0;
    s_tready                   = '0;
    unique case (r_tx_st)
      T_IDLE: if (w_any) w_tx_nxt = T_HDR;
      T_HDR: begin
        tx_udp_hdr_valid = 1'b1;
        if (tx_udp_hdr_ready) w_tx_nxt = T_PAY;
      end
      T_PAY: begin
        tx_udp_payload_axis_tdata  = s_tdata[int'(r_g)*8 +: 8];
        tx_udp_payload_axis_tvalid = s_tvalid[r_g];
        tx_udp_payload_axis_tlast  = s_tlast[r_g];
        tx_udp_payload_axis_tuser  = s_tuser[r_g];
        s_tready[r_g] = tx_udp_payload_axis_tready;
        if (w_tx_end) w_tx_nxt = T_IDLE;
      end
      default: w_tx_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st <= T_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_len   <= '0;
      r_dip   <= '0;
      r_dport <= '0;
    end else begin
      r_tx_st <= w_tx_nxt;
      // Header fields freeze at grant; later RX rebinds cannot disturb them.
      if (r_tx_st == T_IDLE && w_any) begin
        r_g     <= w_pick;
        r_len   <= s_len[int'(w_pick)*16 +: 16] + 16'd8;
        r_dip   <= r_ctx_ip[w_pick];
        r_dport <= r_ctx_port[w_pick];
      end
      if (w_tx_end)
        r_ptr <= (r_g == IW'(NUM_CH - 1)) ? '0 : r_g + 1'b1;
    end
  end

  assign tx_udp_ip_source_ip = local_ip;
  assign tx_udp_ip_dest_ip   = r_dip;
  assign tx_udp_source_port  = BASE_PORT + 16'(r_g);
  assign tx_udp_dest_port    = r_dport;
  assign tx_udp_length       = r_len;
  assign tx_udp_ip_ttl       = TTL;
  assign tx_udp_ip_dscp      = 6'd0;
  assign tx_udp_ip_ecn       = 2'd0;
  assign tx_udp_checksum     = 16'd0;

endmodule
